// File: rtl/alu_bist.sv
// Built-in self-test controller for a 4-bit registered ALU: sweeps every op/a/b vector
// and counts mismatches. Define ALU_BIST_FAILLOG_EN to capture the first failing vector.
module alu_bist #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [1:0]  alu_op,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_y,
  input  logic        alu_carry,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] err_count,
  output logic [1:0]  fail_op,
  output logic [3:0]  fail_a,
  output logic [3:0]  fail_b
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // One in-flight vector: the index {op,a,b} and whether it was really issued.
  typedef struct packed {
    logic       valid;
    logic [9:0] vec;
  } cmp_t;

  state_e      state_q, state_d;
  logic [9:0]  vec_q, vec_d;
  logic [1:0]  drain_q, drain_d;
  logic [10:0] err_q, err_d;
  logic        pass_q, pass_d;
  cmp_t        pipe_q [ALU_LAT];
  cmp_t        pipe_d [ALU_LAT];
  cmp_t        pipe_out;
  logic [4:0]  exp_res;
  logic        mismatch;
  logic        start_ok;

  function automatic logic [4:0] expected_result(input logic [9:0] v);
    logic [3:0] a;
    logic [3:0] b;
    a = v[7:4];
    b = v[3:0];
    case (v[9:8])
      2'b00:   expected_result = {1'b0, a} + {1'b0, b};
      2'b01:   expected_result = {1'b0, a} - {1'b0, b};
      2'b10:   expected_result = {1'b0, a & b};
      default: expected_result = {1'b0, a | b};
    endcase
  endfunction

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign pipe_out = pipe_q[ALU_LAT-1];
  assign exp_res  = expected_result(pipe_out.vec);
  assign mismatch = pipe_out.valid && ({alu_carry, alu_y} != exp_res);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    drain_d = drain_q;
    err_d   = err_q;
    pass_d  = pass_q;

    if (mismatch) begin
      err_d = err_q + 11'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_RUN;
          vec_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (vec_q == 10'h3FF) begin
          state_d = S_DRAIN;
          vec_d   = '0;
          drain_d = '0;
        end else begin
          vec_d = vec_q + 10'd1;
        end
      end
      S_DRAIN: begin
        // The last vector's compare lands on the same edge that enters DONE.
        if (drain_q == 2'(ALU_LAT - 1)) begin
          state_d = S_DONE;
          drain_d = '0;
          pass_d  = (err_d == 11'd0);
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_d[0] = '{valid: (state_q == S_RUN), vec: vec_q};
    for (int k = 1; k < ALU_LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      drain_q <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  // NOTE: the compare pipeline is reset so a stale valid entry can never count against a new run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < ALU_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < ALU_LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign alu_op    = vec_q[9:8];
  assign alu_a     = vec_q[7:4];
  assign alu_b     = vec_q[3:0];
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef ALU_BIST_FAILLOG_EN
  logic [9:0] fail_q, fail_d;

  // err_q==0 marks the first mismatch of the run; later ones leave the log alone.
  always_comb begin
    fail_d = fail_q;
    if (start_ok) begin
      fail_d = '0;
    end else if (mismatch && (err_q == 11'd0)) begin
      fail_d = pipe_out.vec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_q <= '0;
    end else begin
      fail_q <= fail_d;
    end
  end

  assign fail_op = fail_q[9:8];
  assign fail_a  = fail_q[7:4];
  assign fail_b  = fail_q[3:0];
`else
  assign fail_op = '0;
  assign fail_a  = '0;
  assign fail_b  = '0;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: two instances (ALU_LAT 1 and 3) driving faultable ALU models,
// with randomized stuck-at faults checked against a sweep-level reference model.
module tb_alu_bist;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic        start_s [2];
  logic [1:0]  op_s    [2];
  logic [3:0]  a_s     [2];
  logic [3:0]  b_s     [2];
  logic [3:0]  y_s     [2];
  logic        carry_s [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        pass_s  [2];
  logic [10:0] err_s   [2];
  logic [1:0]  fop_s   [2];
  logic [3:0]  fa_s    [2];
  logic [3:0]  fb_s    [2];

  alu_bist #(.ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[0]),
    .alu_op(op_s[0]), .alu_a(a_s[0]), .alu_b(b_s[0]),
    .alu_y(y_s[0]), .alu_carry(carry_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
    .fail_op(fop_s[0]), .fail_a(fa_s[0]), .fail_b(fb_s[0])
  );

  alu_bist #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_s[1]),
    .alu_op(op_s[1]), .alu_a(a_s[1]), .alu_b(b_s[1]),
    .alu_y(y_s[1]), .alu_carry(carry_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
    .fail_op(fop_s[1]), .fail_a(fa_s[1]), .fail_b(fb_s[1])
  );

  // Stuck-at masks on {carry,y}, per instance.
  logic [4:0] sa0_m [2];
  logic [4:0] sa1_m [2];

  function automatic logic [4:0] alu_ref(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = (a >= b) ? (a - b) : (a - b + 32);
      2:       r = a & b;
      default: r = a | b;
    endcase
    return r[4:0];
  endfunction

  function automatic logic [4:0] faulty(input int s, input logic [4:0] r);
    return (r & ~sa0_m[s]) | sa1_m[s];
  endfunction

  logic [4:0] m0_q;
  logic [4:0] m1_q [3];
  always @(posedge clk) begin
    m0_q    <= faulty(0, alu_ref(int'(op_s[0]), int'(a_s[0]), int'(b_s[0])));
    m1_q[0] <= faulty(1, alu_ref(int'(op_s[1]), int'(a_s[1]), int'(b_s[1])));
    m1_q[1] <= m1_q[0];
    m1_q[2] <= m1_q[1];
  end
  assign y_s[0]     = m0_q[3:0];
  assign carry_s[0] = m0_q[4];
  assign y_s[1]     = m1_q[2][3:0];
  assign carry_s[1] = m1_q[2][4];

  // Whole-sweep reference: count vectors the faulty ALU gets wrong, remember the first.
  task automatic model_run(input int s, output int errs, output int first);
    logic [4:0] good;
    errs  = 0;
    first = 0;
    for (int v = 0; v < 1024; v++) begin
      good = alu_ref(v / 256, (v / 16) % 16, v % 16);
      if (faulty(s, good) != good) begin
        if (errs == 0) first = v;
        errs++;
      end
    end
  endtask

  task automatic run_test(input int s, input bit extra);
    int lat, errs, first, c0, n, busy_n, done_n;
    lat = (s == 1) ? 3 : 1;
    model_run(s, errs, first);
    @(posedge clk); #1;
    c0 = cyc;
    start_s[s] = 1'b1;
    busy_n = 0;
    done_n = -1;
    for (int k = 0; k < 1100 && done_n < 0; k++) begin
      @(posedge clk); #1;
      n = cyc - c0;
      start_s[s] = extra && (n == 10 || n == 500);
      if (n == 1) begin
        check("clr_done", done_s[s], 0);
        check("clr_err", err_s[s], 0);
        check("clr_pass", pass_s[s], 0);
      end
      if (n >= 1 && n <= 1024) check("vec", {op_s[s], a_s[s], b_s[s]}, n - 1);
      if (n == 1025) check("vec_idle", {op_s[s], a_s[s], b_s[s]}, 0);
      if (busy_s[s]) busy_n++;
      if (done_s[s]) done_n = n;
    end
    start_s[s] = 1'b0;
    check("timeout", done_n >= 0, 1);
    check("done_at", done_n, 1025 + lat);
    check("busy_cycles", busy_n, 1024 + lat);
    check("err_count", err_s[s], errs);
    check("pass", pass_s[s], errs == 0);
`ifdef ALU_BIST_FAILLOG_EN
    check("fail_op", fop_s[s], (errs > 0) ? first / 256 : 0);
    check("fail_a", fa_s[s], (errs > 0) ? (first / 16) % 16 : 0);
    check("fail_b", fb_s[s], (errs > 0) ? first % 16 : 0);
`else
    check("fail_vec", {fop_s[s], fa_s[s], fb_s[s]}, 0);
`endif
    @(posedge clk); #1;
    check("done_hold", done_s[s], 1);
    check("busy_done", busy_s[s], 0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 2; s++) begin
      check({tag, "_alu"}, {op_s[s], a_s[s], b_s[s]}, 0);
      check({tag, "_flags"}, {busy_s[s], done_s[s], pass_s[s]}, 0);
      check({tag, "_err"}, err_s[s], 0);
      check({tag, "_fail"}, {fop_s[s], fa_s[s], fb_s[s]}, 0);
    end
  endtask

  task automatic set_fault(input int s, input logic [4:0] sa0, input logic [4:0] sa1);
    sa0_m[s] = sa0;
    sa1_m[s] = sa1 & ~sa0;
  endtask

  task automatic reset_mid_run();
    int c0;
    set_fault(0, 5'd0, 5'd0);
    @(posedge clk); #1;
    c0 = cyc;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    while (cyc - c0 < 300) begin
      @(posedge clk); #1;
    end
    check("mid_run_busy", busy_s[0], 1);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk) rst = 1'b1;
    run_test(0, 1'b0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0;
      sa0_m[s]   = '0;
      sa1_m[s]   = '0;
    end
    #12;
    check_all_zero("reset");
    @(negedge clk) rst = 1'b1;

    run_test(0, 1'b0);
    run_test(0, 1'b0);
    set_fault(0, 5'b00001, 5'b00000);
    run_test(0, 1'b0);
    set_fault(0, 5'b10000, 5'b00000);
    run_test(0, 1'b0);
    set_fault(0, 5'd0, 5'd0);

    run_test(1, 1'b1);
    set_fault(1, 5'b00001, 5'b00000);
    run_test(1, 1'b0);
    set_fault(1, 5'd0, 5'd0);

    for (int r = 0; r < 4; r++) begin
      int s;
      s = $urandom_range(0, 1);
      set_fault(s, 5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : 5'd0);
      run_test(s, 1'($urandom_range(0, 1)));
      set_fault(s, 5'd0, 5'd0);
    end

    reset_mid_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
